// File: rtl/dca_matrix_store_row_packer.sv
// DCA matrix store row packer.
// Takes one matrix row at a time from the tensor side, slices it into AXI
// write beats (one burst per row, wlast on the final beat), counts the B
// responses and reports completion and sticky response errors.
module dca_matrix_store_row_packer #(
    parameter  int MATRIX_NUM_ROW = 4,
    parameter  int MATRIX_NUM_COL = 4,
    parameter  int BW_ELEMENT     = 32,
    parameter  int BW_AXI_DATA    = 32,
    localparam int BW_ROW         = MATRIX_NUM_COL * BW_ELEMENT,
    localparam int NUM_BEAT       = BW_ROW / BW_AXI_DATA,
    localparam int BW_NUM_ROW     = $clog2(MATRIX_NUM_ROW + 1)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     cmd_valid,
    input  logic [BW_NUM_ROW-1:0]    cmd_num_rows,
    output logic                     cmd_ready,
    input  logic                     row_valid,
    input  logic [BW_ROW-1:0]        row_data,
    output logic                     row_ready,
    output logic                     wvalid,
    output logic [BW_AXI_DATA-1:0]   wdata,
    output logic [BW_AXI_DATA/8-1:0] wstrb,
    output logic                     wlast,
    input  logic                     wready,
    input  logic                     bvalid,
    input  logic [1:0]               bresp,
    output logic                     bready,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    localparam int BW_BEAT = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ROW, SEND, WAIT_RESP} state_t;

    state_t                               state, state_nxt;
    logic [NUM_BEAT-1:0][BW_AXI_DATA-1:0] row_buf;
    logic [BW_BEAT-1:0]                   beat_cnt;
    logic [BW_NUM_ROW-1:0]                num_rows, row_cnt, resp_cnt;
    logic [BW_NUM_ROW-1:0]                row_cnt_inc, resp_cnt_nxt;
    logic                                 out_en, done_q, error_q;
    logic                                 cmd_hs, row_hs, w_hs, b_hs, last_beat;

    assign cmd_hs       = cmd_valid & cmd_ready;
    assign row_hs       = row_valid & row_ready;
    assign w_hs         = wvalid & wready;
    assign b_hs         = bvalid & bready;
    assign last_beat    = (beat_cnt == BW_BEAT'(NUM_BEAT - 1));
    assign row_cnt_inc  = row_cnt + 1'b1;
    // Response count as it will be after this cycle, so a B handshake in the
    // same cycle counts toward completion.
    assign resp_cnt_nxt = resp_cnt + BW_NUM_ROW'(b_hs);
    assign done         = done_q;
    assign error        = error_q;

    // State register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cmd_hs) state_nxt = (cmd_num_rows == '0) ? IDLE : WAIT_ROW;
            WAIT_ROW:  if (row_hs) state_nxt = SEND;
            SEND:      if (w_hs && last_beat)
                           state_nxt = (row_cnt_inc == num_rows) ? WAIT_RESP : WAIT_ROW;
            WAIT_RESP: if (resp_cnt_nxt == num_rows) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Handshake and W-channel outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        row_ready = 1'b0;
        wvalid    = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        wlast     = 1'b0;
        bready    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:      cmd_ready = out_en;
            WAIT_ROW:  begin row_ready = 1'b1; bready = 1'b1; busy = 1'b1; end
            SEND: begin
                wvalid = 1'b1;
                wdata  = row_buf[beat_cnt];
                wstrb  = '1;
                wlast  = last_beat;
                bready = 1'b1;
                busy   = 1'b1;
            end
            WAIT_RESP: begin bready = 1'b1; busy = 1'b1; end
            default:   ;
        endcase
    end

    // Row buffer: single entry, only written in WAIT_ROW so beats stay stable.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)      row_buf <= '0;
        else if (row_hs) row_buf <= row_data;
    end

    // Counters, done pulse and sticky error. out_en keeps cmd_ready low while
    // reset is applied and for the first cycle after it.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            out_en   <= 1'b0;
            num_rows <= '0;
            row_cnt  <= '0;
            resp_cnt <= '0;
            beat_cnt <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            out_en <= 1'b1;
            if (clear) begin
                num_rows <= '0;
                row_cnt  <= '0;
                resp_cnt <= '0;
                beat_cnt <= '0;
                done_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (cmd_hs) begin
                    num_rows <= cmd_num_rows;
                    row_cnt  <= '0;
                    resp_cnt <= '0;
                    beat_cnt <= '0;
                    error_q  <= 1'b0;
                    done_q   <= (cmd_num_rows == '0);
                end
                if (row_hs) beat_cnt <= '0;
                if (w_hs) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    if (last_beat) row_cnt <= row_cnt_inc;
                end
                if (b_hs) begin
                    resp_cnt <= resp_cnt_nxt;
                    if (bresp != 2'b00) error_q <= 1'b1;
                end
                if (state == WAIT_RESP && resp_cnt_nxt == num_rows) done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dca_matrix_store_row_packer.sv
// Bench for dca_matrix_store_row_packer: table of store commands plus
// hand-written sequences for early/coincident B, clear and reset mid-burst.
module tb_dca_matrix_store_row_packer;
    localparam int NR = 4, NC = 4, BE = 32, BA = 32;
    localparam int BW_ROW = NC * BE, NUM_BEAT = BW_ROW / BA, BW_NUM_ROW = $clog2(NR + 1);

    logic                  clk = 1'b0, rstnn = 1'b0, clear = 1'b0;
    logic                  cmd_valid = 1'b0, row_valid = 1'b0;
    logic [BW_NUM_ROW-1:0] cmd_num_rows = '0;
    logic [BW_ROW-1:0]     row_data = '0;
    logic                  wready = 1'b1, bvalid = 1'b0;
    logic [1:0]            bresp = 2'b00;
    logic                  cmd_ready, row_ready, wvalid, wlast, bready, busy, done, error;
    logic [BA-1:0]         wdata;
    logic [BA/8-1:0]       wstrb;

    dca_matrix_store_row_packer #(
        .MATRIX_NUM_ROW(NR), .MATRIX_NUM_COL(NC), .BW_ELEMENT(BE), .BW_AXI_DATA(BA)
    ) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_num_rows(cmd_num_rows), .cmd_ready(cmd_ready),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [BA-1:0] data; logic last; } beat_t;
    typedef struct {
        int                    nrows;
        logic [3:0][BW_ROW-1:0] rows;    // rows[0] is sent first
        logic                  stall;    // wready pattern 1-0-0-1
        logic [3:0][1:0]       bresp;    // bresp[0] is the first response
        logic                  exp_err;
    } vec_t;

    beat_t exp_q[$];
    int total = 0, bad = 0;
    int wh_cnt = 0, wv_cnt = 0, rr_cnt = 0, done_cnt = 0, wlast_cnt = 0;
    logic b_fire = 1'b0;

    // Monitor / scoreboard: every wvalid cycle must present the queue head.
    initial forever begin
        @(negedge clk);
        b_fire = bvalid && bready;
        if (row_ready) rr_cnt++;
        if (done) done_cnt++;
        if (wvalid) begin
            wv_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL w_unexpected: got wdata=%h wlast=%b, required no beat", wdata, wlast);
            end else if (wdata !== exp_q[0].data || wlast !== exp_q[0].last || wstrb !== {(BA/8){1'b1}}) begin
                bad++;
                $display("FAIL w_beat: got data=%h last=%b strb=%h, required data=%h last=%b strb=all-ones",
                         wdata, wlast, wstrb, exp_q[0].data, exp_q[0].last);
            end
            if (wready) begin
                wh_cnt++;
                if (wlast) wlast_cnt++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    // wready driver.
    logic stall_mode = 1'b0;
    int   wcyc = 0;
    initial forever begin
        @(posedge clk); #1;
        wcyc++;
        wready = stall_mode ? ((wcyc % 4 == 0) || (wcyc % 4 == 3)) : 1'b1;
    end

    // Automatic B responder: one response per completed row burst.
    logic            auto_b = 1'b1;
    logic [3:0][1:0] cur_bresp = '0;
    int              b_sent = 0, b_base = 0;
    logic [1:0]      bi;
    initial forever begin
        @(posedge clk); #1;
        if (auto_b) begin
            if (b_fire) begin bvalid = 1'b0; b_sent++; end
            if (!bvalid && wlast_cnt > b_sent) begin
                bi     = 2'(b_sent - b_base);
                bvalid = 1'b1;
                bresp  = cur_bresp[bi];
            end
        end else begin
            b_sent = wlast_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wvalid"}, wvalid, 0);
        chk({nm, "_wdata"}, wdata, 0);
        chk({nm, "_wlast"}, wlast, 0);
        chk({nm, "_wstrb"}, wstrb, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_row_ready"}, row_ready, 0);
        chk({nm, "_bready"}, bready, 0);
        chk({nm, "_cmd_ready"}, cmd_ready, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_error"}, error, 0);
    endtask

    task automatic push_row(input logic [BW_ROW-1:0] row);
        for (int b = 0; b < NUM_BEAT; b++) exp_q.push_back('{row[b*BA +: BA], b == NUM_BEAT - 1});
    endtask

    task automatic send_cmd(input int n);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin step(); t++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_num_rows = BW_NUM_ROW'(n);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_row(input logic [BW_ROW-1:0] row);
        int t = 0;
        row_valid = 1'b1;
        row_data  = row;
        while (row_ready !== 1'b1 && t < 200) begin step(); t++; end
        chk("row_ready_wait", row_ready, 1);
        push_row(row);
        step();
        row_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 300) begin step(); t++; end
        chk("done_wait", done_cnt != d0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0 = done_cnt, w0 = wh_cnt, v0 = wv_cnt, r0 = rr_cnt;
        stall_mode = v.stall;
        cur_bresp  = v.bresp;
        b_base     = b_sent;
        send_cmd(v.nrows);
        chk("error_clr_on_cmd", error, 0);
        if (v.nrows == 0) chk("done_after_cmd0", done, 1);
        for (int r = 0; r < v.nrows; r++) send_row(v.rows[r]);
        wait_done(d0);
        repeat (3) step();
        chk("done_once", done_cnt - d0, 1);
        chk("beat_count", wh_cnt - w0, NUM_BEAT * v.nrows);
        chk("error_final", error, v.exp_err);
        chk("busy_end", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
        if (v.nrows == 0) begin
            chk("no_wvalid", wv_cnt - v0, 0);
            chk("no_row_ready", rr_cnt - r0, 0);
        end
        stall_mode = 1'b0;
    endtask

    localparam logic [BW_ROW-1:0] R0 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [BW_ROW-1:0] R1 = 128'h88888888_77777777_66666666_55555555;
    localparam logic [BW_ROW-1:0] R2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
    localparam logic [BW_ROW-1:0] R3 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

    initial begin
        vec_t vt[6];
        vec_t vc;
        int   d0, w0, t;
        vt[0] = '{2, {R3, R2, R1, R0}, 1'b0, {2'b00, 2'b00, 2'b00, 2'b00}, 1'b0};
        vt[1] = '{1, {R0, R1, R3, R2}, 1'b1, {2'b00, 2'b00, 2'b00, 2'b00}, 1'b0};
        vt[2] = '{2, {R0, R1, R2, R3}, 1'b1, {2'b00, 2'b00, 2'b10, 2'b00}, 1'b1};
        vt[3] = '{0, {R0, R0, R0, R0}, 1'b0, {2'b00, 2'b00, 2'b00, 2'b00}, 1'b0};
        vt[4] = '{4, {R2, R3, R1, R0}, 1'b0, {2'b00, 2'b00, 2'b00, 2'b11}, 1'b1};
        vt[5] = '{3, {R0, R3, R0, R1}, 1'b1, {2'b00, 2'b00, 2'b00, 2'b00}, 1'b0};
        vc    = '{1, {R0, R0, R0, R3}, 1'b0, {2'b00, 2'b00, 2'b00, 2'b00}, 1'b0};

        #2;
        chk_all_zero("reset");
        repeat (2) step();
        rstnn = 1'b1;
        repeat (2) step();
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_bready", bready, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Early B after row 0, then a B coinciding with the final wlast.
        auto_b = 1'b0;
        d0 = done_cnt; w0 = wh_cnt;
        send_cmd(2);
        send_row(R1);
        t = 0;
        while (wh_cnt - w0 < NUM_BEAT && t < 50) begin step(); t++; end
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("early_b_no_done", done_cnt - d0, 0);
        chk("early_b_busy", busy, 1);
        send_row(R2);
        t = 0;
        while (!(wvalid && wlast) && t < 50) begin step(); t++; end
        chk("coinc_wlast_seen", wvalid && wlast, 1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        wait_done(d0);
        repeat (3) step();
        chk("coinc_done_once", done_cnt - d0, 1);
        chk("coinc_busy", busy, 0);
        chk("coinc_error", error, 0);
        chk("coinc_beats", wh_cnt - w0, 2 * NUM_BEAT);
        auto_b = 1'b1;

        // clear while beat 2 of the first row is on the bus.
        d0 = done_cnt; w0 = wh_cnt;
        send_cmd(2);
        send_row(R0);
        t = 0;
        while (wh_cnt - w0 < 2 && t < 50) begin step(); t++; end
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_q.delete();
        chk("clear_wvalid", wvalid, 0);
        chk("clear_busy", busy, 0);
        chk("clear_cmd_ready", cmd_ready, 1);
        repeat (3) step();
        chk("clear_no_done", done_cnt - d0, 0);
        run_vec(vc);

        // Asynchronous reset while beat 2 of the first row is on the bus.
        w0 = wh_cnt;
        send_cmd(2);
        send_row(R1);
        t = 0;
        while (wh_cnt - w0 < 2 && t < 50) begin step(); t++; end
        rstnn = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        repeat (2) step();
        rstnn = 1'b1;
        repeat (2) step();
        run_vec(vc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
